// File: rtl/phase_scheduler.sv
// Round-robin phase scheduler for a four-approach intersection with emergency
// preemption; one approach at a time goes green -> yellow -> all-red.
module phase_scheduler #(
    parameter int unsigned MIN_GREEN    = 4,
    parameter int unsigned MAX_GREEN    = 16,
    parameter int unsigned YELLOW_TIME  = 3,
    parameter int unsigned ALL_RED_TIME = 1,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic [3:0] emg_req,
    output logic [7:0] lights,
    output logic [3:0] grant,
    output logic [1:0] phase,
    output logic       emg_active
);

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2
    } phase_e;

    localparam logic [CNT_W-1:0] MIN_G  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MAX_G  = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] YEL_T  = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] AR_T   = CNT_W'(ALL_RED_TIME);
    localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] timer_adv_s;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic             emg_active_q, emg_active_d;
    logic [7:0]       lights_q, lights_d;

    function automatic logic [3:0] lowest_one(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    // First set bit after ptr, wrapping; the smallest offset overwrites last.
    function automatic logic [3:0] rr_pick(input logic [3:0] v, input logic [1:0] ptr);
        logic [3:0] r;
        logic [1:0] idx;
        r = 4'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            r   = v[idx] ? (4'b0001 << idx) : r;
        end
        return r;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        case (oh)
            4'b0001: return 2'd0;
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] decode_lights(input phase_e ph, input logic [3:0] g);
        logic [1:0] color;
        logic [7:0] l;
        case (ph)
            PH_GREEN:  color = 2'b10;
            PH_YELLOW: color = 2'b01;
            default:   color = 2'b00;
        endcase
        l = 8'd0;
        for (int i = 0; i < 4; i++) begin
            l[2*i +: 2] = g[i] ? color : 2'b00;
        end
        return l;
    endfunction

    // Timer value this edge would produce if the phase does not change.
    always_comb begin
        if (!tick) begin
            timer_adv_s = timer_q;
        end else if (timer_q >= MAX_G) begin
            timer_adv_s = MAX_G;
        end else begin
            timer_adv_s = timer_q + CNT_1;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        phase_d      = phase_q;
        timer_d      = timer_adv_s;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        emg_active_d = emg_active_q;
        case (phase_q)
            PH_ALL_RED: begin
                grant_d      = 4'd0;
                emg_active_d = 1'b0;
                if ((timer_adv_s >= AR_T) && ((|req) || (|emg_req))) begin
                    phase_d = PH_GREEN;
                    timer_d = '0;
                    if (|emg_req) begin
                        grant_d      = lowest_one(emg_req);
                        emg_active_d = 1'b1;
                    end else begin
                        grant_d  = rr_pick(req, rr_ptr_q);
                        rr_ptr_d = onehot_idx(grant_d);
                    end
                end else begin
                    phase_d = PH_ALL_RED;
                end
            end
            PH_GREEN: begin
                if (|(emg_req & grant_q)) begin
                    phase_d = PH_GREEN;
                end else begin
                    // Emergency service ends here; normal rules resume on the same edge.
                    emg_active_d = 1'b0;
                    if (|(emg_req & ~grant_q)) begin
                        phase_d = PH_YELLOW;
                        timer_d = '0;
                    end else if ((timer_adv_s >= MIN_G) && (|(req & ~grant_q)) &&
                                 (!(|(req & grant_q)) || (timer_adv_s >= MAX_G))) begin
                        phase_d = PH_YELLOW;
                        timer_d = '0;
                    end else begin
                        phase_d = PH_GREEN;
                    end
                end
            end
            PH_YELLOW: begin
                if (timer_adv_s >= YEL_T) begin
                    phase_d      = PH_ALL_RED;
                    timer_d      = '0;
                    grant_d      = 4'd0;
                    emg_active_d = 1'b0;
                end else begin
                    phase_d = PH_YELLOW;
                end
            end
            default: begin
                phase_d      = PH_ALL_RED;
                timer_d      = '0;
                grant_d      = 4'd0;
                emg_active_d = 1'b0;
            end
        endcase
        lights_d = decode_lights(phase_d, grant_d);
    end

    // State and output registers; reset forces all-red with N next in line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q      <= PH_ALL_RED;
            timer_q      <= '0;
            grant_q      <= 4'd0;
            rr_ptr_q     <= 2'd3;
            emg_active_q <= 1'b0;
            lights_q     <= 8'd0;
        end else begin
            phase_q      <= phase_d;
            timer_q      <= timer_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            emg_active_q <= emg_active_d;
            lights_q     <= lights_d;
        end
    end

    assign lights     = lights_q;
    assign grant      = grant_q;
    assign phase      = phase_q;
    assign emg_active = emg_active_q;

endmodule

// File: doc/phase_scheduler.md
Name: phase_scheduler

Overview:
Demand-driven phase scheduler for the four-approach intersection (N, S, E, W). It grants green to exactly one approach at a time using round-robin arbitration over vehicle requests. Each grant is bounded by min/max green timers and followed by yellow and all-red clearance. Emergency requests preempt normal service; the 8-bit light bus is driven directly to the signal heads.

Parameters:
MIN_GREEN, 4, minimum green duration in ticks before normal termination is allowed
MAX_GREEN, 16, green duration in ticks after which a contested green is terminated
YELLOW_TIME, 3, yellow duration in ticks (never truncated)
ALL_RED_TIME, 1, all-red clearance in ticks
CNT_W, 8, phase timer width; must hold MAX_GREEN

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
tick  input  1  timing strobe; all phase timers advance only on cycles with tick=1
req  input  4  vehicle demand per approach, bit0=N, bit1=S, bit2=E, bit3=W, level-sensitive
emg_req  input  4  emergency preemption request, same bit order, level-sensitive
lights  output  8  {W,E,S,N}, 2 bits each: RED=00, YELLOW=01, GREEN=10
grant  output  4  one-hot approach currently green or yellow; 0 in ALL_RED
phase  output  2  0=ALL_RED, 1=GREEN, 2=YELLOW
emg_active  output  1  current grant was issued for an emergency request

Behaviour:
- Reset (rst=0, asynchronous): phase=ALL_RED, timer=0, grant=0, lights=0, emg_active=0, rr_ptr=3 (so N wins first). All outputs are registered or decoded from registers; no combinational input-to-output paths.
- Timer: cleared to 0 on every phase entry. Increments by 1 on each tick=1 cycle and saturates at MAX_GREEN. "After k ticks" means the k-th tick edge in that phase.
- ALL_RED:
  - Exits on the edge where timer reaches ALL_RED_TIME and (|req or |emg_req) is true; otherwise remains in ALL_RED with the timer saturated.
  - Winner selection: lowest-index emg_req bit if any (sets emg_active=1); otherwise the first set req bit searching rr_ptr+1, rr_ptr+2, ... modulo 4 (emg_active=0, rr_ptr ← winner).
  - Emergency grants do not update rr_ptr.
  - Next phase=GREEN; grant=winner.
- GREEN (approach g). Evaluated every cycle; the first matching rule wins:
  1. emg_req[g]=1 → hold green; MAX_GREEN is ignored.
  2. Any emg_req bit other than g is set → go to YELLOW on the next edge, even if MIN_GREEN has not elapsed.
  3. timer ≥ MIN_GREEN and demand from another approach (req & ~(1<<g) ≠ 0) and (req[g]=0 or timer ≥ MAX_GREEN) → YELLOW.
  4. Otherwise hold. With no competing demand, the block rests in green indefinitely.
- Clearing emg_active: it clears when a green that holds an emergency grant sees emg_req[g]=0. That green then follows normal rules using the current timer value.
- YELLOW: lasts exactly YELLOW_TIME ticks, then ALL_RED. Requests never shorten it, including emergency requests.
- Lights decode: the granted approach shows GREEN or YELLOW per phase; all other approaches show RED. In ALL_RED, lights=8'h00. At most one approach is non-red at any time, enforced by construction.
- Simultaneous events:
  - When req and emg_req for different approaches are both set at ALL_RED exit, the emergency wins.
  - When several emg_req bits are set, the lowest index wins.
- Holding at ALL_RED exit: a request that drops before the ALL_RED exit edge is not served.
- tick=0 freezes every timer; state changes driven by emergencies still occur (GREEN→YELLOW).
- Reset mid-phase: lights go to 0 immediately. After release, at least ALL_RED_TIME ticks of all-red elapse before any green.

Test Plan:
- Power-up: rst low then high, tick=1 every cycle, req=4'b0001 → after 1 tick lights=8'h02, grant=4'b0001, phase=1; held green indefinitely while req=0001.
- Max-green: req=4'b0101 held → N green 16 ticks, lights=8'h01 for 3 ticks, 8'h00 for 1 tick, then lights=8'h20 (E green), rr_ptr=2.
- Gap-out: N green, req[0] dropped at tick 2, req[1]=1 → yellow starts at tick 4 (MIN_GREEN), S green lights=8'h08 four ticks later.
- Preemption: N green at tick 1, emg_req=4'b1000 → yellow next edge, 3 yellow, 1 all-red, lights=8'h80, emg_active=1. Green is held past 16 ticks while emg_req[3]=1 and req=0001. After emg_req drops, W yellows and N is served.
- Round-robin fairness: req=4'b1111 constant → grant sequence N,S,E,W,N, each green exactly 16 ticks.
- Tick gating and reset: tick=0 for 10 cycles during yellow → lights stay 8'h01. Assert rst mid-yellow → lights=8'h00 the same cycle, grant=0, restart from N.
